// File: rtl/gpio_bus_slave.sv
// gpio_bus_slave: memory-mapped GPIO block for a simple core's data-memory path.
// Registers are in a 32-byte window starting at BASE_ADDR. All accesses are word accesses.
//   0x00 DATA_OUT RW   0x04 DIR RW      0x08 DATA_IN RO
//   0x0C IRQ_EN RW     0x10 IRQ_STATUS W1C   0x14 EDGE_SEL RW (0 rising, 1 falling)
//   0x18 and 0x1C are unused: they read as zero and ignore writes.
// Ports:
//   clk, rst      single clock; asynchronous active-high reset
//   WE, A, WD     store enable, byte address and store data from the core
//   RD, Sel       combinational read data; window-hit flag used by the top level
//   gpio_in       asynchronous pad inputs, synchronized and debounced
//   gpio_out      pad output values
//   gpio_oe       pad output enables (1 = drive)
//   irq           level interrupt = |(IRQ_STATUS & IRQ_EN)
module gpio_bus_slave #(
  parameter int          N_PINS     = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0100,
  parameter int          DEB_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WE,
  input  logic [31:0]       A,
  input  logic [31:0]       WD,
  output logic [31:0]       RD,
  output logic              Sel,
  input  logic [N_PINS-1:0] gpio_in,
  output logic [N_PINS-1:0] gpio_out,
  output logic [N_PINS-1:0] gpio_oe,
  output logic              irq
);

  // Counter only needs to reach DEB_CYCLES-1; reaching it on a differing edge commits.
  localparam int             CW      = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEB_CYCLES - 1);
  // Window bounds are compared with 33 bits so a window near the top of memory cannot wrap.
  localparam logic [32:0]    WIN_LO  = {1'b0, BASE_ADDR};
  localparam logic [32:0]    WIN_HI  = WIN_LO + 33'd31;

  logic [N_PINS-1:0] data_out_r;
  logic [N_PINS-1:0] dir_r;
  logic [N_PINS-1:0] irq_en_r;
  logic [N_PINS-1:0] irq_status_r;
  logic [N_PINS-1:0] edge_sel_r;
  logic [N_PINS-1:0] sync1_r;
  logic [N_PINS-1:0] sync2_r;
  logic [N_PINS-1:0] stable_r;
  logic [CW-1:0]     cnt_r [N_PINS];

  logic [31:0]       off_s;
  logic [2:0]        reg_idx_s;
  logic              wr_s;
  logic [N_PINS-1:0] wd_s;
  logic [N_PINS-1:0] differ_s;
  logic [N_PINS-1:0] commit_s;
  logic [N_PINS-1:0] event_s;
  logic [N_PINS-1:0] w1c_s;
  logic [N_PINS-1:0] reg_val_s;
  logic [31:0]       rd_s;
  logic              unused_s;

  assign Sel       = ({1'b0, A} >= WIN_LO) && ({1'b0, A} <= WIN_HI);
  assign off_s     = A - BASE_ADDR;
  assign reg_idx_s = off_s[4:2];
  assign wr_s      = WE & Sel;
  assign wd_s      = WD[N_PINS-1:0];
  assign unused_s  = ^{off_s[31:5], off_s[1:0], WD};

  assign gpio_out = data_out_r;
  assign gpio_oe  = dir_r;
  assign irq      = |(irq_status_r & irq_en_r);
  assign RD       = rd_s;

  // Per-pin debounce decision: a pin commits when it has differed for DEB_CYCLES edges.
  // An interrupt event is a commit whose new level matches the selected edge and is enabled.
  always_comb begin
    differ_s = sync2_r ^ stable_r;
    commit_s = {N_PINS{1'b0}};
    for (int i = 0; i < N_PINS; i++) begin
      if (differ_s[i] && (cnt_r[i] == CNT_MAX)) begin
        commit_s[i] = 1'b1;
      end else begin
        commit_s[i] = 1'b0;
      end
    end
    // New level is sync2; rising (sel=0) matches 1, falling (sel=1) matches 0.
    event_s = commit_s & irq_en_r & (sync2_r ^ edge_sel_r);
  end

  // Write-one-to-clear mask for IRQ_STATUS.
  always_comb begin
    if (wr_s && (reg_idx_s == 3'd4)) begin
      w1c_s = wd_s;
    end else begin
      w1c_s = {N_PINS{1'b0}};
    end
  end

  // Read mux; upper bits and out-of-window reads are zero.
  always_comb begin
    reg_val_s = {N_PINS{1'b0}};
    rd_s      = 32'h0000_0000;
    case (reg_idx_s)
      3'd0:    reg_val_s = data_out_r;
      3'd1:    reg_val_s = dir_r;
      3'd2:    reg_val_s = stable_r;
      3'd3:    reg_val_s = irq_en_r;
      3'd4:    reg_val_s = irq_status_r;
      3'd5:    reg_val_s = edge_sel_r;
      default: reg_val_s = {N_PINS{1'b0}};
    endcase
    if (Sel) begin
      rd_s[N_PINS-1:0] = reg_val_s;
    end else begin
      rd_s = 32'h0000_0000;
    end
  end

  // Software-visible registers; a new event wins over a same-edge W1C clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_r   <= {N_PINS{1'b0}};
      dir_r        <= {N_PINS{1'b0}};
      irq_en_r     <= {N_PINS{1'b0}};
      irq_status_r <= {N_PINS{1'b0}};
      edge_sel_r   <= {N_PINS{1'b0}};
    end else begin
      if (wr_s) begin
        case (reg_idx_s)
          3'd0:    data_out_r <= wd_s;
          3'd1:    dir_r      <= wd_s;
          3'd3:    irq_en_r   <= wd_s;
          3'd5:    edge_sel_r <= wd_s;
          default: ;
        endcase
      end
      irq_status_r <= (irq_status_r & ~w1c_s) | event_s;
    end
  end

  // Two-flop synchronizer followed by per-pin debounce counters feeding the stable level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r  <= {N_PINS{1'b0}};
      sync2_r  <= {N_PINS{1'b0}};
      stable_r <= {N_PINS{1'b0}};
      for (int i = 0; i < N_PINS; i++) begin
        cnt_r[i] <= {CW{1'b0}};
      end
    end else begin
      sync1_r <= gpio_in;
      sync2_r <= sync1_r;
      for (int i = 0; i < N_PINS; i++) begin
        if (!differ_s[i]) begin
          cnt_r[i] <= {CW{1'b0}};
        end else if (commit_s[i]) begin
          cnt_r[i]    <= {CW{1'b0}};
          stable_r[i] <= sync2_r[i];
        end else begin
          cnt_r[i] <= cnt_r[i] + CW'(1);
        end
      end
    end
  end

endmodule

// File: doc/gpio_bus_slave.md
GPIO_BUS_SLAVE -- requirements
Module: gpio_bus_slave

Interface
REQ-001 SHALL have parameter N_PINS, default 16, giving the number of GPIO pins (1..32).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0100, giving the byte base of a 32-byte register window.
REQ-003 SHALL have parameter DEB_CYCLES, default 4, giving the debounce length in clocks (>=1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port WE, input, 1 bit: store enable from the core's data-memory path.
REQ-007 SHALL have port A, input, 32 bits: byte address from the core's ALU result.
REQ-008 SHALL have port WD, input, 32 bits: store data.
REQ-009 SHALL have port RD, output, 32 bits: combinational read data.
REQ-010 SHALL have port Sel, output, 1 bit: high when A is inside the window; the top level uses it to steer RD over data memory and to gate data-memory writes.
REQ-011 SHALL have port gpio_in, input, N_PINS bits: asynchronous pad inputs.
REQ-012 SHALL have port gpio_out, output, N_PINS bits: pad output values.
REQ-013 SHALL have port gpio_oe, output, N_PINS bits: pad output enables, where 1 means drive.
REQ-014 SHALL have port irq, output, 1 bit: level interrupt.

Function
REQ-015 SHALL assert Sel when BASE_ADDR <= A <= BASE_ADDR+0x1F; A[1:0] are ignored, so all accesses are word accesses.
REQ-016 SHALL implement the following registers at the given offsets: 0x00 DATA_OUT RW; 0x04 DIR RW; 0x08 DATA_IN RO; 0x0C IRQ_EN RW; 0x10 IRQ_STATUS W1C; 0x14 EDGE_SEL RW, where per bit 0 selects rising and 1 selects falling.
REQ-017 SHALL perform a register write on the rising clk edge where WE=1 and Sel=1, using only WD[N_PINS-1:0].
REQ-018 SHALL ignore writes to DATA_IN and to offsets 0x18 and 0x1C; reads of those offsets SHALL return 0.
REQ-019 SHALL drive RD combinationally from current register state, with bits [31:N_PINS] = 0, and drive RD = 0 when Sel = 0.
REQ-020 SHALL drive gpio_out directly from DATA_OUT and gpio_oe directly from DIR; a write becomes visible on the pins immediately after the write edge.
REQ-021 SHALL pass each gpio_in bit through a two-flop synchronizer (sync1 -> sync2).
REQ-022 SHALL keep a per-pin debounce counter: it resets to 0 on any edge where sync2 == stable, and increments otherwise.
REQ-023 SHALL copy sync2 into stable on the DEB_CYCLES-th consecutive differing edge and clear the counter on that same edge; DATA_IN reads stable.
REQ-024 SHALL treat a pin that toggles back before the count completes as no change: stable is untouched and the counter returns to 0.
REQ-025 SHALL, on the edge where stable changes, set IRQ_STATUS[i] if IRQ_EN[i] = 1 and the change matches EDGE_SEL[i] (0->1 for rising, 1->0 for falling).
REQ-026 SHALL clear each IRQ_STATUS bit written as 1; when a clear and a new event hit the same bit on the same edge, set SHALL win.
REQ-027 SHALL NOT clear IRQ_STATUS when IRQ_EN is cleared.
REQ-028 SHALL drive irq combinationally as |(IRQ_STATUS & IRQ_EN).
REQ-029 SHALL give a pin change occurring before edge 0 its DATA_IN and IRQ_STATUS update at edge DEB_CYCLES+1, i.e. the (DEB_CYCLES+2)-th edge.
REQ-030 SHALL keep debouncing pins with DIR = 1, so DATA_IN always reflects the pad.

Reset
REQ-031 SHALL, while rst = 1 and independent of clk, set DATA_OUT, DIR, IRQ_EN, IRQ_STATUS, EDGE_SEL, sync1, sync2, stable and all counters to 0; gpio_out = 0, gpio_oe = 0, irq = 0.
REQ-032 SHALL abandon any debounce in progress when reset is asserted mid-count; after release, a pin held high is treated as a fresh 0->1 change.
REQ-033 SHALL perform the first register write only on a rising edge where rst = 0.

Verification
REQ-034 Bench SHALL check: reset; write 0x00 = 0x00A5 and 0x04 = 0x00FF -> on the next cycle gpio_out = 0x00A5, gpio_oe = 0x00FF, and a read of 0x04 returns 0x000000FF.
REQ-035 Bench SHALL check: gpio_in[3] 0->1 before edge 0, DEB_CYCLES = 4 -> DATA_IN[3] = 0 through edge 4, = 1 after edge 5.
REQ-036 Bench SHALL check: gpio_in[2] high for 3 clocks, then low -> DATA_IN[2] stays 0 and IRQ_STATUS stays 0.
REQ-037 Bench SHALL check: IRQ_EN = 0x1, EDGE_SEL = 0x1, pin 0 falls after being stable high -> IRQ_STATUS = 0x1 and irq = 1; write 0x10 = 0x1 -> irq = 0 on the next cycle.
REQ-038 Bench SHALL check: W1C to bit 0 on the same edge as a new bit-0 event -> IRQ_STATUS[0] remains 1.
REQ-039 Bench SHALL check: A = BASE_ADDR+0x18, WE = 1 -> Sel = 1, RD = 0, no register changes; A = BASE_ADDR+0x20 -> Sel = 0, RD = 0; assert rst mid-debounce -> all outputs 0 immediately.
